board_draw_sequencer: RTL and testbench
=======================================

// Module: board_draw_sequencer
// PURPOSE
//  Sequences the 160x120 3-bit-colour VGA adapter plot port for the reversi board.
//  Accepts one draw command at a time over a valid/ready handshake:
//  fill a board cell, draw a bordered cell, or clear the screen.
//  Emits one pixel write per clock on x/y/colour/plot, then pulses done.
//  Sits between game control and vga_adapter. It is the only driver of the adapter.
// PARAMETERS
//  CELL_SIZE     12      cell edge in pixels
//  BOARD_X0      32      x of cell (0,0) top-left pixel
//  BOARD_Y0      12      y of cell (0,0) top-left pixel
//  SCREEN_W      160     screen width (clear sweep x range 0..SCREEN_W-1)
//  SCREEN_H      120     screen height (clear sweep y range 0..SCREEN_H-1)
//  BORDER_COLOUR 3'b111  border colour for op 01 (GRID_BORDER_EN only)
//  Constraint: BOARD_X0+8*CELL_SIZE<=SCREEN_W, BOARD_Y0+8*CELL_SIZE<=SCREEN_H.
// PORTS
//  clock       in   1  system clock (50 MHz)
//  resetn      in   1  asynchronous reset, active-low
//  cmd_valid   in   1  command present
//  cmd_ready   out  1  block can accept a command (high iff state==IDLE)
//  cmd_op      in   2  00 fill cell, 01 bordered cell, 10 clear screen, 11 no-op
//  cmd_row     in   3  board row 0..7
//  cmd_col     in   3  board column 0..7
//  cmd_colour  in   3  fill colour {R,G,B}
//  x           out  8  pixel x to adapter
//  y           out  7  pixel y to adapter
//  colour      out  3  pixel colour to adapter
//  plot        out  1  pixel write strobe
//  busy        out  1  high from the accept cycle+1 through the DONE cycle
//  done        out  1  one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0.
//  cmd_ready reads 1 during reset, but no transfer occurs while resetn=0.
//  Accept: cmd_valid & cmd_ready on a rising edge (cycle T). op/row/col/colour latched.
//  Inputs changing after T are ignored. cmd_valid is ignored while not IDLE.
//  FSM: IDLE -> SETUP (T+1) -> SWEEP -> DONE -> IDLE.
//  - SETUP computes the origin: ox=BOARD_X0+col*CELL_SIZE, oy=BOARD_Y0+row*CELL_SIZE.
//    For a clear, ox=0 and oy=0. The origin math is 8-bit and must not overflow under the constraint.
//  - SWEEP: raster order, x fastest. One pixel per cycle with plot=1, starting at T+2.
//    x/y/colour are registered and valid in the same cycle as plot.
//  - End of row: x returns to ox, y increments. The last pixel is the bottom-right corner.
//  - Cell ops: CELL_SIZE^2 pixels (144). Clear: SCREEN_W*SCREEN_H pixels (19200) in cmd_colour.
//  - DONE: exactly 1 cycle after the last pixel. plot=0, done=1, cmd_ready=0. IDLE next cycle.
//  - op 11: skips SWEEP (IDLE->SETUP->DONE), no plot; done at T+2.
//  Timing (N pixels): plot at T+2..T+N+1, done at T+N+2, cmd_ready=1 at T+N+3.
//  Back-to-back: a command held valid across DONE is accepted on the first IDLE cycle.
//  Reset mid-sweep: plot drops asynchronously; no done pulse; the command is discarded.
//  plot is never high outside SWEEP. x<SCREEN_W and y<SCREEN_H are guaranteed whenever plot=1.
// CONFIGURATION
//  GRID_BORDER_EN defined:
//  - op 01 paints cell-edge pixels (local x or y equal to 0 or CELL_SIZE-1) in BORDER_COLOUR.
//  - Interior pixels use cmd_colour. Pixel count and timing are identical to op 00.
//  GRID_BORDER_EN undefined: op 01 behaves exactly as op 00. BORDER_COLOUR is unused.
// TESTING
//  1. Reset, then op00 row0 col0 colour 010 accepted at T:
//     plot T+2..T+145; first (32,12), last (43,23), all colour 010;
//     done only at T+146; ready at T+147.
//  2. op00 row7 col7: first pixel (116,96), last (127,107); exactly 144 plot cycles.
//  3. op10 colour 001: 19200 plots; first (0,0), (159,0) then (0,1), last (159,119); done at T+19202.
//  4. GRID_BORDER_EN, op01 row2 col3 colour 100:
//     (68,36)=111, (69,37)=100, (79,47)=111; exactly 44 border-coloured pixels.
//     Without the macro, all 144 pixels are 100.
//  5. Pull resetn low at the 50th plot of a cell fill: plot=0 immediately; no done;
//     after release, ready=1 and a new command runs its full 144 pixels.
//  6. cmd_valid toggling and cmd fields changing during a sweep: no second accept,
//     and pixels match the latched command. op11 gives done at T+2 with zero plots.

Source files
------------

// File: rtl/board_draw_sequencer.sv
// board_draw_sequencer
//   Drives the 160x120, 3-bit-colour VGA adapter plot port for the reversi
//   board. One draw command is taken at a time over a valid/ready handshake.
//   The block then writes one pixel per clock and pulses done at the end.
//   It is the only driver of the adapter.
//
//   Ports
//     clock       in   system clock
//     resetn      in   asynchronous reset, active-low
//     cmd_valid   in   command present
//     cmd_ready   out  command can be accepted (high exactly when idle)
//     cmd_op      in   00 fill cell, 01 bordered cell, 10 clear screen, 11 no-op
//     cmd_row     in   board row 0..7
//     cmd_col     in   board column 0..7
//     cmd_colour  in   fill colour {R,G,B}
//     x, y        out  registered pixel coordinate
//     colour      out  registered pixel colour
//     plot        out  pixel write strobe
//     busy        out  command in flight (cycle after accept through done)
//     done        out  one-cycle completion pulse
//
//   Configuration macro: GRID_BORDER_EN
//     defined   : op 01 paints cell-edge pixels in BORDER_COLOUR
//     undefined : op 01 is identical to op 00
module board_draw_sequencer #(
    parameter int unsigned CELL_SIZE     = 12,
    parameter int unsigned BOARD_X0      = 32,
    parameter int unsigned BOARD_Y0      = 12,
    parameter int unsigned SCREEN_W      = 160,
    parameter int unsigned SCREEN_H      = 120,
    parameter logic [2:0]  BORDER_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_row,
    input  logic [2:0] cmd_col,
    input  logic [2:0] cmd_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SWEEP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_FILL   = 2'b00,
        OP_BORDER = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_NOP    = 2'b11
    } op_t;

`ifdef GRID_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    localparam logic [7:0] CELL_W      = 8'(CELL_SIZE);
    localparam logic [6:0] CELL_H      = 7'(CELL_SIZE);
    localparam logic [7:0] CELL_LAST_X = 8'(CELL_SIZE - 1);
    localparam logic [6:0] CELL_LAST_Y = 7'(CELL_SIZE - 1);
    localparam logic [7:0] SCR_LAST_X  = 8'(SCREEN_W - 1);
    localparam logic [6:0] SCR_LAST_Y  = 7'(SCREEN_H - 1);
    localparam logic [7:0] ORG_X0      = 8'(BOARD_X0);
    localparam logic [6:0] ORG_Y0      = 7'(BOARD_Y0);

    state_t     state;
    op_t        op_q;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic [2:0] colour_q;
    logic [7:0] lx;         // local x within the swept rectangle
    logic [6:0] ly;         // local y within the swept rectangle

    logic       is_clear;
    logic [7:0] w_last;
    logic [6:0] h_last;
    logic [7:0] ox;
    logic [6:0] oy;         // SCREEN_H <= 128, so the y origin fits 7 bits
    logic       row_end;
    logic       last_px;
    logic [7:0] nxt_lx;
    logic [6:0] nxt_ly;
    logic       on_edge;
    logic [2:0] pix_colour;

    assign cmd_ready = (state == S_IDLE);

    always_comb begin
        is_clear = (op_q == OP_CLEAR);
        w_last   = is_clear ? SCR_LAST_X : CELL_LAST_X;
        h_last   = is_clear ? SCR_LAST_Y : CELL_LAST_Y;
        ox       = is_clear ? '0 : ORG_X0 + ({5'b0, col_q} * CELL_W);
        oy       = is_clear ? '0 : ORG_Y0 + ({4'b0, row_q} * CELL_H);
        row_end  = (lx == w_last);
        last_px  = row_end && (ly == h_last);

        // Colour is registered alongside x/y, so it is derived from the
        // coordinate that is about to be emitted, not the current one.
        if (state == S_SETUP) begin
            nxt_lx = '0;
            nxt_ly = '0;
        end else begin
            nxt_lx = row_end ? '0 : lx + 8'd1;
            nxt_ly = row_end ? ly + 7'd1 : ly;
        end

        on_edge = (nxt_lx == '0) || (nxt_lx == CELL_LAST_X) ||
                  (nxt_ly == '0) || (nxt_ly == CELL_LAST_Y);
        pix_colour = (BORDER_EN && (op_q == OP_BORDER) && on_edge)
                     ? BORDER_COLOUR : colour_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            op_q     <= OP_FILL;
            row_q    <= '0;
            col_q    <= '0;
            colour_q <= '0;
            lx       <= '0;
            ly       <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= op_t'(cmd_op);
                        row_q    <= cmd_row;
                        col_q    <= cmd_col;
                        colour_q <= cmd_colour;
                        busy     <= 1'b1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (op_q == OP_NOP) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        lx     <= '0;
                        ly     <= '0;
                        x      <= ox;
                        y      <= oy;
                        colour <= pix_colour;
                        plot   <= 1'b1;
                        state  <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (last_px) begin
                        plot  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        lx     <= nxt_lx;
                        ly     <= nxt_ly;
                        x      <= row_end ? ox : x + 8'd1;
                        y      <= row_end ? y + 7'd1 : y;
                        colour <= pix_colour;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_draw_sequencer.sv
// Testbench for board_draw_sequencer: directed commands with hand-computed
// pixel positions, counts and handshake timing.
module tb_board_draw_sequencer;

    logic       clock;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_row;
    logic [2:0] cmd_col;
    logic [2:0] cmd_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    board_draw_sequencer dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_colour (cmd_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_asserts = 0;
    int n_fail    = 0;

    // Per-command capture, filled by run_cmd and checked by the test tasks.
    int   n_plot, n_done, done_k, first_k, last_k, n_col_eq, n_border;
    int   n_oob, n_ready_busy, n_busy_low;
    int   fx, fy, lxp, lyp, p160x, p160y, p161x, p161y;
    logic ready_after, busy_after, plot_after_rst, done_after_rst;
    bit   timed_out;
    logic [3:0] fb [160][120];

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] row,
                           input logic [2:0] col, input logic [2:0] col_in,
                           input bit wiggle, input int abort_at);
        int  k;
        bit  finished;
        n_plot = 0; n_done = 0; done_k = 0; first_k = 0; last_k = 0;
        n_col_eq = 0; n_border = 0; n_oob = 0; n_ready_busy = 0; n_busy_low = 0;
        fx = -1; fy = -1; lxp = -1; lyp = -1;
        p160x = -1; p160y = -1; p161x = -1; p161y = -1;
        ready_after = 1'bx; busy_after = 1'bx;
        plot_after_rst = 1'bx; done_after_rst = 1'bx;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                fb[i][j] = 4'hF;
        @(negedge clock);
        cmd_op = op; cmd_row = row; cmd_col = col; cmd_colour = col_in;
        cmd_valid = 1'b1;
        @(posedge clock);
        k = 0;
        finished = 1'b0;
        while (!finished && k < 20100) begin
            @(negedge clock);
            k++;
            if (plot) begin
                n_plot++;
                if (n_plot == 1) begin fx = x; fy = y; first_k = k; end
                if (n_plot == 160) begin p160x = x; p160y = y; end
                if (n_plot == 161) begin p161x = x; p161y = y; end
                lxp = x; lyp = y; last_k = k;
                if (x < 160 && y < 120) fb[x][y] = {1'b0, colour};
                else n_oob++;
                if (colour == col_in) n_col_eq++;
                if (colour == 3'b111) n_border++;
            end
            if (done) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
            if (done_k == 0 || k == done_k) begin
                if (cmd_ready) n_ready_busy++;
                if (!busy) n_busy_low++;
            end
            if (abort_at != 0 && n_plot == abort_at) begin
                resetn = 1'b0;
                #1;
                plot_after_rst = plot;
                done_after_rst = done;
                finished = 1'b1;
            end else if (done_k != 0 && k == done_k + 1) begin
                ready_after = cmd_ready;
                busy_after  = busy;
                finished = 1'b1;
            end
            if (wiggle && !finished && done_k == 0) begin
                cmd_valid  = 1'($urandom_range(0, 1));
                cmd_op     = 2'($urandom_range(0, 3));
                cmd_row    = 3'($urandom_range(0, 7));
                cmd_col    = 3'($urandom_range(0, 7));
                cmd_colour = 3'($urandom_range(0, 7));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        timed_out = !finished;
    endtask

    task automatic test_reset;
        #3;
        n_asserts++; if ({x, y, colour, plot, busy, done} !== 21'd0) begin n_fail++; $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, want all 0", x, y, colour, plot, busy, done); end
        n_asserts++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = 2'b00;
        repeat (3) @(negedge clock);
        n_asserts++; if ({busy, plot} !== 2'b00) begin n_fail++; $display("FAIL reset_no_transfer: got busy=%b plot=%b want 0 0", busy, plot); end
        cmd_valid = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_fill_first_cell;
        run_cmd(2'b00, 3'd0, 3'd0, 3'b010, 1'b0, 0);
        n_asserts++; if (n_plot !== 144) begin n_fail++; $display("FAIL t1_count: got %0d want 144", n_plot); end
        n_asserts++; if (first_k !== 2 || last_k !== 145) begin n_fail++; $display("FAIL t1_plot_window: got T+%0d..T+%0d want T+2..T+145", first_k, last_k); end
        n_asserts++; if (fx !== 32 || fy !== 12) begin n_fail++; $display("FAIL t1_first: got (%0d,%0d) want (32,12)", fx, fy); end
        n_asserts++; if (lxp !== 43 || lyp !== 23) begin n_fail++; $display("FAIL t1_last: got (%0d,%0d) want (43,23)", lxp, lyp); end
        n_asserts++; if (n_col_eq !== 144) begin n_fail++; $display("FAIL t1_colour: got %0d pixels of 010 want 144", n_col_eq); end
        n_asserts++; if (done_k !== 146 || n_done !== 1) begin n_fail++; $display("FAIL t1_done: got T+%0d x%0d want T+146 x1", done_k, n_done); end
        n_asserts++; if (ready_after !== 1'b1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL t1_ready_T147: got ready=%b busy=%b want 1 0", ready_after, busy_after); end
        n_asserts++; if (n_ready_busy !== 0 || n_busy_low !== 0) begin n_fail++; $display("FAIL t1_handshake: got ready-while-busy=%0d busy-low=%0d want 0 0", n_ready_busy, n_busy_low); end
    endtask

    task automatic test_fill_last_cell;
        run_cmd(2'b00, 3'd7, 3'd7, 3'b110, 1'b0, 0);
        n_asserts++; if (n_plot !== 144) begin n_fail++; $display("FAIL t2_count: got %0d want 144", n_plot); end
        n_asserts++; if (fx !== 116 || fy !== 96) begin n_fail++; $display("FAIL t2_first: got (%0d,%0d) want (116,96)", fx, fy); end
        n_asserts++; if (lxp !== 127 || lyp !== 107) begin n_fail++; $display("FAIL t2_last: got (%0d,%0d) want (127,107)", lxp, lyp); end
    endtask

    task automatic test_clear;
        run_cmd(2'b10, 3'd5, 3'd6, 3'b001, 1'b0, 0);
        n_asserts++; if (n_plot !== 19200) begin n_fail++; $display("FAIL t3_count: got %0d want 19200", n_plot); end
        n_asserts++; if (fx !== 0 || fy !== 0) begin n_fail++; $display("FAIL t3_first: got (%0d,%0d) want (0,0)", fx, fy); end
        n_asserts++; if (p160x !== 159 || p160y !== 0 || p161x !== 0 || p161y !== 1) begin n_fail++; $display("FAIL t3_row_wrap: got (%0d,%0d)->(%0d,%0d) want (159,0)->(0,1)", p160x, p160y, p161x, p161y); end
        n_asserts++; if (lxp !== 159 || lyp !== 119) begin n_fail++; $display("FAIL t3_last: got (%0d,%0d) want (159,119)", lxp, lyp); end
        n_asserts++; if (done_k !== 19202) begin n_fail++; $display("FAIL t3_done: got T+%0d want T+19202", done_k); end
        n_asserts++; if (n_col_eq !== 19200 || n_oob !== 0) begin n_fail++; $display("FAIL t3_colour_bounds: got %0d colour 001, %0d out of range, want 19200 0", n_col_eq, n_oob); end
    endtask

    task automatic test_border;
        run_cmd(2'b01, 3'd2, 3'd3, 3'b100, 1'b0, 0);
        n_asserts++; if (n_plot !== 144 || done_k !== 146) begin n_fail++; $display("FAIL t4_count_timing: got %0d pixels done T+%0d want 144 T+146", n_plot, done_k); end
        n_asserts++; if (fx !== 68 || fy !== 36 || lxp !== 79 || lyp !== 47) begin n_fail++; $display("FAIL t4_span: got (%0d,%0d)..(%0d,%0d) want (68,36)..(79,47)", fx, fy, lxp, lyp); end
        n_asserts++; if (fb[69][37] !== 4'b0100) begin n_fail++; $display("FAIL t4_interior: got %b want 0100", fb[69][37]); end
`ifdef GRID_BORDER_EN
        n_asserts++; if (fb[68][36] !== 4'b0111 || fb[79][47] !== 4'b0111) begin n_fail++; $display("FAIL t4_corners: got %b %b want 0111 0111", fb[68][36], fb[79][47]); end
        n_asserts++; if (n_border !== 44 || n_col_eq !== 100) begin n_fail++; $display("FAIL t4_edge_count: got %0d border %0d fill want 44 100", n_border, n_col_eq); end
`else
        n_asserts++; if (fb[68][36] !== 4'b0100 || fb[79][47] !== 4'b0100) begin n_fail++; $display("FAIL t4_corners: got %b %b want 0100 0100", fb[68][36], fb[79][47]); end
        n_asserts++; if (n_col_eq !== 144 || n_border !== 0) begin n_fail++; $display("FAIL t4_all_fill: got %0d fill %0d border want 144 0", n_col_eq, n_border); end
`endif
    endtask

    task automatic test_reset_mid_sweep;
        int extra_done;
        run_cmd(2'b00, 3'd4, 3'd4, 3'b011, 1'b0, 50);
        n_asserts++; if (plot_after_rst !== 1'b0 || done_after_rst !== 1'b0) begin n_fail++; $display("FAIL t5_async_drop: got plot=%b done=%b want 0 0", plot_after_rst, done_after_rst); end
        extra_done = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) extra_done++;
        end
        n_asserts++; if (extra_done !== 0 || n_done !== 0) begin n_fail++; $display("FAIL t5_no_done: got %0d done pulses want 0", extra_done + n_done); end
        resetn = 1'b1;
        @(negedge clock);
        n_asserts++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL t5_idle_after: got ready=%b busy=%b want 1 0", cmd_ready, busy); end
        run_cmd(2'b00, 3'd1, 3'd2, 3'b110, 1'b0, 0);
        n_asserts++; if (n_plot !== 144 || fx !== 56 || fy !== 24 || done_k !== 146) begin n_fail++; $display("FAIL t5_rerun: got %0d pixels first (%0d,%0d) done T+%0d want 144 (56,24) T+146", n_plot, fx, fy, done_k); end
    endtask

    task automatic test_input_churn;
        run_cmd(2'b00, 3'd3, 3'd5, 3'b101, 1'b1, 0);
        n_asserts++; if (n_ready_busy !== 0 || n_done !== 1) begin n_fail++; $display("FAIL t6_no_reaccept: got ready-while-busy=%0d done=%0d want 0 1", n_ready_busy, n_done); end
        n_asserts++; if (n_plot !== 144 || fx !== 92 || fy !== 48 || lxp !== 103 || lyp !== 59) begin n_fail++; $display("FAIL t6_latched_span: got %0d (%0d,%0d)..(%0d,%0d) want 144 (92,48)..(103,59)", n_plot, fx, fy, lxp, lyp); end
        n_asserts++; if (n_col_eq !== 144) begin n_fail++; $display("FAIL t6_latched_colour: got %0d pixels of 101 want 144", n_col_eq); end
    endtask

    task automatic test_nop;
        run_cmd(2'b11, 3'd1, 3'd1, 3'b111, 1'b0, 0);
        n_asserts++; if (n_plot !== 0 || done_k !== 2 || n_done !== 1) begin n_fail++; $display("FAIL nop: got %0d plots done T+%0d x%0d want 0 T+2 x1", n_plot, done_k, n_done); end
        n_asserts++; if (ready_after !== 1'b1) begin n_fail++; $display("FAIL nop_ready: got %b want 1", ready_after); end
    endtask

    task automatic test_back_to_back;
        int   k, np, fk, dk, bfx, bfy;
        logic d2, r3, r4;
        k = 0; np = 0; fk = 0; dk = 0; bfx = -1; bfy = -1;
        d2 = 1'bx; r3 = 1'bx; r4 = 1'bx;
        @(negedge clock);
        cmd_op = 2'b11; cmd_row = 3'd0; cmd_col = 3'd0; cmd_colour = 3'b000;
        cmd_valid = 1'b1;
        @(posedge clock);
        while (dk == 0 && k < 400) begin
            @(negedge clock);
            k++;
            if (k == 2) begin
                d2 = done;
                cmd_op = 2'b00; cmd_row = 3'd1; cmd_col = 3'd1; cmd_colour = 3'b011;
            end
            if (k == 3) r3 = cmd_ready;
            if (k == 4) begin r4 = cmd_ready; cmd_valid = 1'b0; end
            if (plot) begin
                np++;
                if (fk == 0) begin fk = k; bfx = x; bfy = y; end
            end
            if (k > 4 && done) dk = k;
        end
        cmd_valid = 1'b0;
        n_asserts++; if (d2 !== 1'b1 || r3 !== 1'b1 || r4 !== 1'b0) begin n_fail++; $display("FAIL b2b_handshake: got done@2=%b ready@3=%b ready@4=%b want 1 1 0", d2, r3, r4); end
        n_asserts++; if (fk !== 5 || bfx !== 44 || bfy !== 24) begin n_fail++; $display("FAIL b2b_second_start: got T+%0d (%0d,%0d) want T+5 (44,24)", fk, bfx, bfy); end
        n_asserts++; if (np !== 144 || dk !== 149) begin n_fail++; $display("FAIL b2b_second_done: got %0d plots done T+%0d want 144 T+149", np, dk); end
    endtask

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
        cmd_row = '0; cmd_col = '0; cmd_colour = '0;
        test_reset;
        test_fill_first_cell;
        test_fill_last_cell;
        test_clear;
        test_border;
        test_reset_mid_sweep;
        test_input_churn;
        test_nop;
        test_back_to_back;
        n_asserts++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL cycle_budget: last command did not finish"); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
